// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage.
// Contents:
//   state_e     - arbiter FSM encoding (IDLE=0, ACCESS=1, RESP=2)
//   DMEM_DEPTH  - default number of 32-bit words in data_memory
//   DMEM_IDX_W  - default word-index width (log2 of DMEM_DEPTH)
//   addr_oor()  - true when a word address falls outside the memory
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_IDX_W = 8;

  // Any bit above the index field, or an index at/above depth, is out of range.
  // The second term only matters when depth is not a power of two.
  function automatic logic addr_oor(input logic [31:0] addr,
                                    input int unsigned depth,
                                    input int unsigned idx_w);
    return ((addr >> idx_w) != 32'd0) || (addr >= depth);
  endfunction

endpackage

// File: rtl/dmem_req_latch.sv
// Per-port request latch and read-result register.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   load_i         - capture we/addr/wdata (port granted in IDLE)
//   we_i, addr_i, wdata_i - live request payload from the port
//   cap_i          - capture read result (this port's read in ACCESS)
//   mem_rdata_i    - combinational read data from data_memory
//   we_o, addr_o, wdata_o - latched payload
//   oor_o          - latched address is out of range
//   rdata_o        - last read result, held until the next read completes
module dmem_req_latch
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int IDX_W = DMEM_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        cap_i,
  input  logic [31:0] mem_rdata_i,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        oor_o,
  output logic [31:0] rdata_o
);

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  assign oor_o   = addr_oor(addr_q, DEPTH, IDX_W);
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (load_i) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      // Out-of-range reads never touch memory and return zero.
      if (cap_i) rdata_q <= oor_o ? 32'd0 : mem_rdata_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data_memory.
// Each access takes IDLE -> ACCESS -> RESP (one access per three cycles).
// Handshake: a port raises reqN with its payload and holds all of it until
// doneN; reqN is only sampled in IDLE, so a reqN still high in IDLE is a new
// request. gntN marks the ACCESS cycle, doneN (with errN) marks RESP.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   reqN, weN, addrN, wdataN   - request from port N (N = 0,1)
//   gntN, doneN, errN, rdataN  - grant, completion, range error, read data
//   mem_we, mem_re, mem_addr, mem_wdata, mem_rdata - data_memory interface
//   dbg_state_o                - current FSM state
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int IDX_W = DMEM_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        done0,
  output logic        err0,
  output logic [31:0] rdata0,
  output logic        gnt1,
  output logic        done1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state_o
);

  state_e state_q;
  logic   ptr_q;   // port that wins a tie
  logic   win_q;   // port owning the current access
  logic   gnt0_q, gnt1_q, done0_q, done1_q, err0_q, err1_q;

  logic        l0_we, l1_we, l0_oor, l1_oor;
  logic [31:0] l0_addr, l1_addr, l0_wdata, l1_wdata;

  logic        any_req, next_win, in_idle, in_access;
  logic        cur_we, cur_oor;
  logic [31:0] cur_addr, cur_wdata;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_access = (state_q == ST_ACCESS);
  assign any_req   = req0 | req1;
  // Tie goes to the pointer's port; otherwise the lone requester wins.
  assign next_win  = (req0 & req1) ? ptr_q : req1;

  dmem_req_latch #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lat0 (
    .clk(clk), .rst(rst),
    .load_i(in_idle & any_req & ~next_win),
    .we_i(we0), .addr_i(addr0), .wdata_i(wdata0),
    .cap_i(in_access & ~win_q & ~l0_we),
    .mem_rdata_i(mem_rdata),
    .we_o(l0_we), .addr_o(l0_addr), .wdata_o(l0_wdata),
    .oor_o(l0_oor), .rdata_o(rdata0)
  );

  dmem_req_latch #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lat1 (
    .clk(clk), .rst(rst),
    .load_i(in_idle & any_req & next_win),
    .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
    .cap_i(in_access & win_q & ~l1_we),
    .mem_rdata_i(mem_rdata),
    .we_o(l1_we), .addr_o(l1_addr), .wdata_o(l1_wdata),
    .oor_o(l1_oor), .rdata_o(rdata1)
  );

  assign cur_we    = win_q ? l1_we    : l0_we;
  assign cur_oor   = win_q ? l1_oor   : l0_oor;
  assign cur_addr  = win_q ? l1_addr  : l0_addr;
  assign cur_wdata = win_q ? l1_wdata : l0_wdata;

  // Decoded from the async-reset state, so reset drops mem_we immediately.
  assign mem_we    = in_access & cur_we & ~cur_oor;
  assign mem_re    = in_access & ~cur_we & ~cur_oor;
  assign mem_addr  = in_access ? cur_addr  : 32'd0;
  assign mem_wdata = in_access ? cur_wdata : 32'd0;

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q <= ST_ACCESS;
            win_q   <= next_win;
            ptr_q   <= ~next_win;
            gnt0_q  <= ~next_win;
            gnt1_q  <= next_win;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_RESP;
          done0_q <= ~win_q;
          done1_q <= win_q;
          err0_q  <= ~win_q & cur_oor;
          err1_q  <= win_q & cur_oor;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, done0, err0, gnt1, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int grants;

  logic [31:0] mem [0:255];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- data_memory model ----------------
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
    .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   {30'd0, gnt1, gnt0}, 32'd0);
    chk({tag, "_done"},  {30'd0, done1, done0}, 32'd0);
    chk({tag, "_err"},   {30'd0, err1, err0}, 32'd0);
    chk({tag, "_memen"}, {30'd0, mem_we, mem_re}, 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[5] = 32'd8;
    mem[6] = 32'd1;
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    #3;
    chk_all_zero("reset");
    step(); step();
    rst = 1'b0;

    // Scenario 1: port 0 reads word 5 alone
    req0 = 1; we0 = 0; addr0 = 32'd5;
    step();
    chk("s1_gnt0", {31'd0, gnt0}, 32'd1);
    chk("s1_gnt1", {31'd0, gnt1}, 32'd0);
    chk("s1_mem_re", {31'd0, mem_re}, 32'd1);
    chk("s1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("s1_mem_addr", mem_addr, 32'd5);
    chk("s1_done_early", {31'd0, done0}, 32'd0);
    step();
    chk("s1_done0", {31'd0, done0}, 32'd1);
    chk("s1_err0", {31'd0, err0}, 32'd0);
    chk("s1_rdata0", rdata0, 32'd8);
    chk("s1_gnt0_off", {31'd0, gnt0}, 32'd0);
    chk("s1_mem_re_off", {31'd0, mem_re}, 32'd0);
    req0 = 0;
    step();
    chk("s1_idle", {30'd0, dbg_state}, 32'd0);
    chk("s1_done0_off", {31'd0, done0}, 32'd0);

    // Scenario 2: port 1 writes word 6, then port 0 reads it back
    req1 = 1; we1 = 1; addr1 = 32'd6; wdata1 = 32'hDEADBEEF;
    step();
    chk("s2_gnt1", {31'd0, gnt1}, 32'd1);
    chk("s2_mem_we", {31'd0, mem_we}, 32'd1);
    chk("s2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("s2_mem_addr", mem_addr, 32'd6);
    step();
    chk("s2_done1", {31'd0, done1}, 32'd1);
    chk("s2_done0", {31'd0, done0}, 32'd0);
    chk("s2_mem6", mem[6], 32'hDEADBEEF);
    chk("s2_rdata1_held", rdata1, 32'd0);
    req1 = 0; we1 = 0;
    step();
    req0 = 1; we0 = 0; addr0 = 32'd6;
    step();
    chk("s2_gnt0", {31'd0, gnt0}, 32'd1);
    step();
    chk("s2_rd_done0", {31'd0, done0}, 32'd1);
    chk("s2_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 0;
    step();

    // Scenario 3: simultaneous reads after reset; port 0 reissues
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1; addr0 = 32'd5; req1 = 1; we1 = 0; addr1 = 32'd6;
    step();
    chk("s3_first_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    step();
    chk("s3_first_done", {30'd0, done1, done0}, 32'd1);
    chk("s3_rdata0", rdata0, 32'd8);
    step();
    step();   // both still high in IDLE: pointer now favours port 1
    chk("s3_second_gnt", {30'd0, gnt1, gnt0}, 32'd2);
    step();
    chk("s3_second_done", {30'd0, done1, done0}, 32'd2);
    chk("s3_rdata1", rdata1, 32'hDEADBEEF);
    req1 = 0;
    step();
    step();
    chk("s3_third_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    step();
    chk("s3_third_done", {30'd0, done1, done0}, 32'd1);
    req0 = 0;
    step();

    // Scenario 4: out-of-range read by port 0
    req0 = 1; we0 = 0; addr0 = 32'd300;
    step();
    chk("s4_gnt0", {31'd0, gnt0}, 32'd1);
    chk("s4_mem_en", {30'd0, mem_we, mem_re}, 32'd0);
    step();
    chk("s4_done_err", {30'd0, done0, err0}, 32'd3);
    chk("s4_rdata0", rdata0, 32'd0);
    chk("s4_rdata1_held", rdata1, 32'hDEADBEEF);
    req0 = 0;
    step();
    chk("s4_err_off", {31'd0, err0}, 32'd0);

    // Scenario 5: reset in the middle of a write access
    req0 = 1; we0 = 1; addr0 = 32'd6; wdata0 = 32'h55;
    step();
    chk("s5_mem_we", {31'd0, mem_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("s5_async");
    req0 = 0; we0 = 0;
    step();
    chk("s5_no_done", {31'd0, done0}, 32'd0);
    chk("s5_mem6", mem[6], 32'hDEADBEEF);
    rst = 1'b0;
    step();
    chk_all_zero("s5_after");

    // Scenario 6: both ports requesting continuously for 12 cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1; addr0 = 32'd5; req1 = 1; addr1 = 32'd6;
    grants = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("s6_gnt_c%0d", i), {30'd0, gnt1, gnt0},
          (i == 1 || i == 7) ? 32'd1 : ((i == 4 || i == 10) ? 32'd2 : 32'd0));
      chk($sformatf("s6_done_c%0d", i), {30'd0, done1, done0},
          (i == 2 || i == 8) ? 32'd1 : ((i == 5 || i == 11) ? 32'd2 : 32'd0));
      grants += int'(gnt0) + int'(gnt1);
    end
    chk("s6_grant_total", grants, 32'd4);
    req0 = 0; req1 = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
